timer: RTL and testbench



---
 rtl/timer.sv | 42 ++++
 tb/tb_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer.sv
// Up-counting interval timer: hit_target flags `target` consecutive cycles of `in`.
// Optional periodic (auto-reload) mode is enabled by defining TIMER_AUTORELOAD_EN.
module timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             in,
  output logic             hit_target
);

  logic [WIDTH-1:0] count;
  logic             at_target;

  // Unsigned compare against the live target; no registered copy of target.
  assign at_target = (count >= target);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!in) begin
      count <= '0;
    end else if (!at_target) begin
      // Only reached when count < target, so the increment cannot wrap.
      count <= count + WIDTH'(1);
    end else begin
`ifdef TIMER_AUTORELOAD_EN
      count <= '0;
`else
      count <= count;
`endif
    end
  end

`ifdef TIMER_AUTORELOAD_EN
  assign hit_target = in & at_target;
`else
  assign hit_target = at_target;
`endif

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer (WIDTH=6): scenario tasks plus randomized run
// against an arithmetic reference model; honours TIMER_AUTORELOAD_EN.
module tb_timer;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] target = '0;
  logic         in = 1'b0;
  logic         hit_target;

  int checks = 0;
  int failures = 0;

  logic exp_q[$];
  int   m_count = 0;

  timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .target     (target),
    .in         (in),
    .hit_target (hit_target)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model: length of the current in=1 run, capped at target
  // (or restarted after reaching it in periodic mode).
  function automatic void model_edge(input logic r, input logic i, input int t);
    if (r || !i) m_count = 0;
    else if (m_count < t) m_count = m_count + 1;
`ifdef TIMER_AUTORELOAD_EN
    else m_count = 0;
`endif
  endfunction

  function automatic logic model_hit(input logic i, input int t);
`ifdef TIMER_AUTORELOAD_EN
    return i && (m_count >= t);
`else
    return m_count >= t;
`endif
  endfunction

  // Driver: apply inputs for one edge, advance the model, sample at negedge.
  task automatic cycle(input logic r, input logic i, input logic [W-1:0] t, output logic got);
    reset = r;
    in = i;
    target = t;
    @(posedge clk);
    model_edge(r, i, int'(t));
    @(negedge clk);
    exp_q.push_back(model_hit(i, int'(t)));
    got = hit_target;
  endtask

  task automatic test_reset();
    logic got, exp;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, W'(60), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || got !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: hit_target=%b required=0", got);
      end
    end
    for (int k = 0; k < 100; k++) begin
      cycle(1'b0, 1'b0, W'(60), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL idle_in_low cycle %0d: hit_target=%b required=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_count_to_target();
    logic got, exp;
    for (int k = 1; k <= 100; k++) begin
      cycle(1'b0, 1'b1, W'(60), got);
      exp = exp_q.pop_front();
`ifdef TIMER_AUTORELOAD_EN
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL periodic_run edge %0d: hit_target=%b required=%b", k, got, exp);
      end
`else
      checks++;
      if (got !== exp || got !== (k >= 60)) begin
        failures++;
        $display("FAIL count_to_60 edge %0d: hit_target=%b required=%b", k, got, (k >= 60));
      end
`endif
    end
  endtask

  task automatic test_drop();
    logic got, exp;
    for (int k = 0; k < 100; k++) begin
      cycle(1'b0, 1'b0, W'(60), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || got !== 1'b0) begin
        failures++;
        $display("FAIL drop_in cycle %0d: hit_target=%b required=0", k, got);
      end
    end
  endtask

  task automatic test_glitch_restart();
    logic got, exp;
    logic pattern [9];
    pattern = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, pattern[k], W'(5), got);
      exp = exp_q.pop_front();
      checks++;
      // Only the 5th edge after the re-raise (index 8) may assert.
      if (got !== exp || got !== (k == 8)) begin
        failures++;
        $display("FAIL glitch_restart step %0d: hit_target=%b required=%b", k, got, (k == 8));
      end
    end
    cycle(1'b0, 1'b0, W'(5), got);
    void'(exp_q.pop_front());
  endtask

  task automatic test_target_zero_and_reset();
    logic got, exp;
    cycle(1'b1, 1'b0, W'(0), got);
    exp = exp_q.pop_front();
    checks++;
`ifdef TIMER_AUTORELOAD_EN
    if (got !== exp || got !== 1'b0) begin
`else
    if (got !== exp || got !== 1'b1) begin
`endif
      failures++;
      $display("FAIL target_zero: hit_target=%b required=%b", got, exp);
    end
    for (int k = 0; k < 7; k++) begin
      cycle(1'b0, 1'b1, W'(10), got);
      void'(exp_q.pop_front());
    end
    cycle(1'b1, 1'b1, W'(10), got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp || got !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run: hit_target=%b required=0", got);
    end
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b1, W'(10), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL resume_after_reset edge %0d: hit_target=%b required=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_target_change();
    logic got, exp;
    cycle(1'b0, 1'b0, W'(20), got);
    void'(exp_q.pop_front());
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, W'(20), got);
      void'(exp_q.pop_front());
    end
    // Lower below the running count, then raise again.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, (k < 2) ? W'(4) : W'(15), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL target_change step %0d: hit_target=%b required=%b", k, got, exp);
      end
    end
  endtask

`ifdef TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    logic got, exp;
    int pulses;
    pulses = 0;
    cycle(1'b0, 1'b0, W'(3), got);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 1'b1, W'(3), got);
      exp = exp_q.pop_front();
      if (got === 1'b1) pulses++;
      checks++;
      if (got !== exp || got !== (k % 4 == 3)) begin
        failures++;
        $display("FAIL autoreload edge %0d: hit_target=%b required=%b", k, got, (k % 4 == 3));
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL autoreload_pulses: got=%0d required=3", pulses);
    end
  endtask
`endif

  task automatic test_random();
    logic got, exp;
    logic [W-1:0] t;
    t = W'($urandom_range(0, 12));
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 15) == 0) t = W'($urandom_range(0, 12));
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), t, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random cycle %0d: hit_target=%b required=%b target=%0d", k, got, exp, t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_to_target();
    test_drop();
    test_glitch_restart();
    test_target_zero_and_reset();
    test_target_change();
`ifdef TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
